gpu_cmd_sender: RTL and testbench

Host-side master for the GPU's 8-bit command bus. Accepts 32-bit GPU instructions on a valid/ready interface, buffers them in a small FIFO, and serializes each one MSB-byte-first onto the bus with a four-phase enable/acknowledge handshake. It is the transmitting end that feeds the GPU's instruction decoder, in the host FPGA or in the simulation harness.

---
 rtl/gpu_bus_pkg.sv | 25 ++
 rtl/gpu_instr_fifo.sv | 71 +++++++
 rtl/gpu_cmd_sender.sv | 173 +++++++++++++++++
 tb/tb_gpu_cmd_sender.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_bus_pkg.sv
// Shared definitions for the host-side GPU command bus sender:
// bus and instruction widths, sender state encoding, watchdog defaults,
// and a byte-select helper used by the serializer.
package gpu_bus_pkg;

  localparam int INSTR_W                = 32;
  localparam int BUS_W                  = 8;
  localparam int BYTES_PER_INSTR        = INSTR_W / BUS_W;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
  localparam int TIMER_W                = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } sender_state_e;

  // Byte idx of an instruction word; idx 3 is the most significant byte.
  function automatic logic [BUS_W-1:0] instr_byte(input logic [INSTR_W-1:0] instr,
                                                 input logic [1:0]         idx);
    return instr[idx*BUS_W +: BUS_W];
  endfunction

endpackage

// File: rtl/gpu_instr_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued GPU instructions.
// A push while full and a pop while empty are ignored; push and pop in the
// same cycle leave the occupancy unchanged.
module gpu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Next pointer and occupancy values
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write
  always_ff @(posedge i_clk) begin
    // NOTE: storage is deliberately not reset; occupancy gates every read, so stale contents are never observed.
    if (push_ok) mem_q[wr_ptr_q] <= i_din;
  end

  assign o_dout  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/gpu_cmd_sender.sv
// Host-side master for the GPU 8-bit command bus. Queues 32-bit instructions
// and sends each MSB byte first with a four-phase o_en / i_ack handshake.
// Optional ack watchdog: define GPU_SENDER_TIMEOUT_EN to enable it.
module gpu_cmd_sender
  import gpu_bus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instruction,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_we,
  output logic               o_en,
  output logic [BUS_W-1:0]   o_data,
  input  logic               i_ack,
  output logic               o_busy,
  output logic               o_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               fifo_pop, fifo_empty, fifo_full;
  logic [INSTR_W-1:0] fifo_dout;
  logic [CW-1:0]      fifo_count, count_after;

  gpu_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_valid),
    .i_din   (i_instruction),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  logic          ack_meta_q, ack_s_q;
  sender_state_e state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic          en_q, en_d, we_q, we_d;
  logic          ready_q, ready_d, busy_q, busy_d;
  logic          timeout;

  // Two-flop synchronizer for the GPU acknowledge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= i_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Handshake sequencer: pop, set up byte, strobe, wait for release
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    instr_d  = instr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          instr_d  = fifo_dout;
          idx_d    = 2'(BYTES_PER_INSTR - 1);
          data_d   = instr_byte(fifo_dout, 2'(BYTES_PER_INSTR - 1));
          state_d  = ST_SETUP;
        end
      end
      // Holding here until ack is low protects against a stuck-high ack.
      ST_SETUP:  if (!ack_s_q) state_d = ST_STROBE;
      ST_STROBE: if (ack_s_q)  state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!ack_s_q) begin
          if (idx_q == 2'd0) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q - 1'b1;
            data_d  = instr_byte(instr_q, idx_q - 1'b1);
            state_d = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A watchdog expiry abandons the rest of the instruction.
    if (timeout) state_d = ST_IDLE;
  end

  // Registered bus strobes and host-side status derived from next state
  always_comb begin
    en_d        = (state_d == ST_STROBE);
    we_d        = (state_d != ST_IDLE);
    count_after = fifo_count + CW'(i_valid && !fifo_full) - CW'(fifo_pop);
    ready_d     = (count_after != CW'(FIFO_DEPTH));
    busy_d      = (state_d != ST_IDLE) || (count_after != '0);
  end

  // Sequencer state and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      instr_q <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

`ifdef GPU_SENDER_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               error_q, error_d;

  assign timeout = ((state_q == ST_STROBE) || (state_q == ST_RELEASE)) &&
                   (timer_q == TIMEOUT_LAST);

  // Watchdog restarts on every state change and runs only while waiting on the GPU
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == ST_STROBE) || (state_q == ST_RELEASE)))
      timer_d = timer_q + 1'b1;
    error_d = error_q | timeout;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  assign o_error = error_q;
`else
  assign timeout = 1'b0;
  assign o_error = 1'b0;
`endif

  assign o_ready = ready_q;
  assign o_we    = we_q;
  assign o_en    = en_q;
  assign o_data  = data_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_gpu_cmd_sender.sv
// Self-checking bench for gpu_cmd_sender: reset values, single transfer,
// back-pressure, reset mid-transfer, stuck-high ack, back-to-back stream
// and, with GPU_SENDER_TIMEOUT_EN, the ack watchdog.
module tb_gpu_cmd_sender;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_instruction;
  logic        i_valid;
  logic        o_ready, o_we, o_en, o_busy, o_error;
  logic [7:0]  o_data;
  logic        i_ack;

  always #5 clk = ~clk;

  gpu_cmd_sender #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_instruction (i_instruction),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_we          (o_we),
    .o_en          (o_en),
    .o_data        (o_data),
    .i_ack         (i_ack),
    .o_busy        (o_busy),
    .o_error       (o_error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle counter and bus monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bytes_q[$];
  int         en_rise[$];
  int         we_rise[$];
  int         we_fall[$];
  int         we_viol   = 0;
  int         stab_viol = 0;
  logic       en_prev = 1'b0, we_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_en && !en_prev) begin
        bytes_q.push_back(o_data);
        en_rise.push_back(cyc);
      end
      if (o_en && !o_we) we_viol <= we_viol + 1;
      if (o_en && en_prev && (o_data !== data_prev)) stab_viol <= stab_viol + 1;
      if (o_we && !we_prev) we_rise.push_back(cyc);
      if (!o_we && we_prev) we_fall.push_back(cyc);
    end
    en_prev   <= o_en;
    we_prev   <= o_we;
    data_prev <= o_data;
  end

  // GPU responder: either forces i_ack, or follows o_en after ack_dly cycles
  int resp_mode = 0;
  bit force_ack = 1'b0;
  int ack_dly   = 0;
  int resp_cnt  = 0;

  initial begin
    i_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_mode == 0) begin
        i_ack    = force_ack;
        resp_cnt = 0;
      end else if (o_en != i_ack) begin
        if (resp_cnt >= ack_dly) begin
          i_ack    = o_en;
          resp_cnt = 0;
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bytes_q.delete();
    en_rise.delete();
    we_rise.delete();
    we_fall.delete();
    we_viol   = 0;
    stab_viol = 0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    while (!o_ready && n < 400) begin
      tick();
      n++;
    end
    check("push_ready", {31'd0, o_ready}, 32'd1);
    i_valid       = 1'b1;
    i_instruction = w;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((o_busy || o_we) && n < max) begin
      tick();
      n++;
    end
    check(name, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic expect_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, bytes_q.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s_byte%0d", name, k), (k < bytes_q.size()) ? bytes_q[k] : 8'hxx, exp[k]);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  e0, e1, e2, e3;   // in bus order
  } vec_t;

  vec_t vec [8];

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [7:0]  eq[$];
    logic [31:0] bp_words [6];
    int          bad;
    int          t_err;

    vec[0] = '{32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    vec[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec[3] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
    vec[4] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
    vec[5] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    vec[6] = '{32'h0F1E2D3C, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    vec[7] = '{32'h5A5AA5A5, 8'h5A, 8'h5A, 8'hA5, 8'hA5};

    bp_words[0] = 32'h01020304;
    bp_words[1] = 32'h05060708;
    bp_words[2] = 32'h090A0B0C;
    bp_words[3] = 32'h0D0E0F10;
    bp_words[4] = 32'h11121314;
    bp_words[5] = 32'h15161718;

    // ---- reset values ----
    i_reset       = 1'b1;
    i_valid       = 1'b0;
    i_instruction = 32'h0;
    repeat (3) tick();
    check("rst_en",    {31'd0, o_en},    32'd0);
    check("rst_we",    {31'd0, o_we},    32'd0);
    check("rst_data",  {24'd0, o_data},  32'h00);
    check("rst_busy",  {31'd0, o_busy},  32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    i_reset = 1'b0;
    #1;
    check("ready_before_edge", {31'd0, o_ready}, 32'd0);
    tick();
    check("ready_after_edge", {31'd0, o_ready}, 32'd1);
    clear_mon();

    // ---- single instruction, 3-cycle responder ----
    resp_mode = 1;
    ack_dly   = 3;
    push_word(vec[0].instr);
    check("we_lat_cycle1", {31'd0, o_we}, 32'd0);
    tick();
    check("we_lat_cycle2", {31'd0, o_we}, 32'd1);
    check("setup_en_low",  {31'd0, o_en}, 32'd0);
    check("setup_data",    {24'd0, o_data}, {24'd0, vec[0].e0});
    wait_idle("single_idle", 200);
    eq = {vec[0].e0, vec[0].e1, vec[0].e2, vec[0].e3};
    expect_bytes("single", eq);
    check("single_en_pulses", en_rise.size(), 32'd4);
    check("single_we_once",   we_rise.size(), 32'd1);
    check("single_we_viol",   we_viol,        32'd0);
    check("single_stab_viol", stab_viol,      32'd0);

    // ---- back-pressure: ack held low, FIFO fills, extra push ignored ----
    do_reset();
    resp_mode = 0;
    force_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("bp_ready_low_when_full", {31'd0, o_ready}, 32'd0);
      i_valid       = 1'b1;
      i_instruction = bp_words[i];
      tick();
    end
    i_valid = 1'b0;
    check("bp_ready_still_low", {31'd0, o_ready}, 32'd0);
    check("bp_busy",            {31'd0, o_busy},  32'd1);
    check("bp_stuck_in_strobe", {31'd0, o_en},    32'd1);
    resp_mode = 1;
    ack_dly   = 1;
    wait_idle("bp_idle", 800);
    eq = {};
    for (int k = 0; k < 20; k++) eq.push_back(8'(k + 1));
    expect_bytes("bp", eq);
    check("bp_stab_viol", stab_viol, 32'd0);

    // ---- reset asserted during STROBE of the second byte ----
    do_reset();
    resp_mode = 1;
    ack_dly   = 3;
    push_word(32'h11223344);
    push_word(32'h55667788);
    begin
      int n = 0;
      while (en_rise.size() < 2 && n < 200) begin
        tick();
        n++;
      end
    end
    check("rm_reached_byte2", en_rise.size(), 32'd2);
    check("rm_en_before",     {31'd0, o_en}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("rm_en",    {31'd0, o_en},   32'd0);
    check("rm_we",    {31'd0, o_we},   32'd0);
    check("rm_data",  {24'd0, o_data}, 32'h00);
    check("rm_busy",  {31'd0, o_busy}, 32'd0);
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (100) tick();
    check("rm_no_more_bytes", bytes_q.size(), 32'd2);
    check("rm_idle_busy",     {31'd0, o_busy}, 32'd0);
    check("rm_idle_we",       {31'd0, o_we},   32'd0);

    // ---- ack stuck high at start: wait in SETUP ----
    do_reset();
    resp_mode = 0;
    force_ack = 1'b1;
    repeat (4) tick();
    push_word(32'hCAFEF00D);
    repeat (20) tick();
    check("ah_en_low",   {31'd0, o_en},   32'd0);
    check("ah_we_high",  {31'd0, o_we},   32'd1);
    check("ah_data",     {24'd0, o_data}, 32'hCA);
    check("ah_no_bytes", bytes_q.size(),  32'd0);
    resp_mode = 1;
    ack_dly   = 3;
    wait_idle("ah_idle", 300);
    eq = {8'hCA, 8'hFE, 8'hF0, 8'h0D};
    expect_bytes("ah", eq);

    // ---- stream of 8 instructions, zero-delay responder ----
    do_reset();
    resp_mode = 1;
    ack_dly   = 0;
    for (int i = 0; i < 8; i++) push_word(vec[i].instr);
    wait_idle("st_idle", 600);
    eq = {};
    for (int i = 0; i < 8; i++) begin
      eq.push_back(vec[i].e0);
      eq.push_back(vec[i].e1);
      eq.push_back(vec[i].e2);
      eq.push_back(vec[i].e3);
    end
    expect_bytes("st", eq);
    bad = 0;
    for (int k = 0; k + 1 < en_rise.size(); k++)
      if (en_rise[k+1] - en_rise[k] != (((k % 4) == 3) ? 8 : 7)) bad++;
    check("st_byte_period_errs", bad, 32'd0);
    check("st_we_rises", we_rise.size(), 32'd8);
    bad = 0;
    for (int k = 0; k + 1 < we_rise.size() && k < we_fall.size(); k++)
      if (we_rise[k+1] - we_fall[k] != 1) bad++;
    check("st_idle_gap_errs", bad, 32'd0);
    check("st_we_viol",   we_viol,   32'd0);
    check("st_stab_viol", stab_viol, 32'd0);

`ifdef GPU_SENDER_TIMEOUT_EN
    // ---- ack never arrives: watchdog fires, next word still sent ----
    do_reset();
    resp_mode = 0;
    force_ack = 1'b0;
    push_word(32'hDEADBEEF);
    push_word(32'h00000011);
    begin
      int n = 0;
      while (!o_error && n < 300) begin
        tick();
        n++;
      end
    end
    t_err = cyc;
    check("to_error_set", {31'd0, o_error}, 32'd1);
    check("to_en_low",    {31'd0, o_en},    32'd0);
    check("to_we_low",    {31'd0, o_we},    32'd0);
    check("to_latency",   (en_rise.size() > 0) ? (t_err - en_rise[0]) : -1, TMO);
    resp_mode = 1;
    ack_dly   = 2;
    wait_idle("to_idle", 300);
    eq = {8'hDE, 8'h00, 8'h00, 8'h00, 8'h11};
    expect_bytes("to", eq);
    check("to_error_sticky", {31'd0, o_error}, 32'd1);
`else
    t_err = 0;
    check("error_tied_low", {31'd0, o_error}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
